uart_tx_param: RTL

Parametrised UART transmitter that replaces the fixed 8N1 transmitter. It adds configurable data width, parity, stop bits and baud divisor, plus a small TX FIFO behind a valid/ready handshake. It sits between the button/debounce control logic and the TxD pin, and accepts words from any producer without that producer needing to pace itself to the baud rate.

---
 rtl/uart_tx_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small TX FIFO.
// Frames are start bit, DATA_BITS data bits (LSB first), optional parity bit,
// then STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   tx_data    - word to queue for transmission
//   tx_valid   - tx_data is valid; pushed when tx_ready is also high
//   tx_ready   - FIFO has room (decoded from the registered count)
//   TxD        - registered serial output, idles high
//   busy       - a frame is in flight or words are queued
//   fifo_count - number of queued words
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned IDX_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time parameter legality checks
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2 in 2..64");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic                   bit_end_c;
    logic                   fifo_empty_c;
    logic                   push_c;
    logic                   pop_c;
    logic [DATA_BITS-1:0]   head_c;
    logic                   head_par_c;

    // Handshake and status decode
    assign fifo_empty_c = (count == '0);
    assign tx_ready     = (count < CNT_W'(FIFO_DEPTH));
    assign push_c       = tx_valid && tx_ready;
    assign bit_end_c    = (baud_cnt == BAUD_LAST);
    assign fifo_count   = count;
    assign busy         = (state != S_IDLE) || !fifo_empty_c;

    // Pop from IDLE, or on the final stop-bit boundary so frames run back-to-back
    assign pop_c = !fifo_empty_c &&
                   ((state == S_IDLE) ||
                    ((state == S_STOP) && bit_end_c && (stop_idx == STOP_LAST)));

    // Parity of the word about to be loaded; odd mode inverts the XOR reduction
    assign head_c     = mem[rd_ptr];
    assign head_par_c = (PARITY == 1) ? ~^head_c : ^head_c;

    // FIFO storage (no reset needed: validity is tracked by count)
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Framing FSM with registered TxD; every bit boundary clears the baud counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            TxD      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else if (pop_c) begin
            state    <= S_START;
            TxD      <= 1'b0;
            baud_cnt <= '0;
            shift    <= head_c;
            par_bit  <= head_par_c;
        end else begin
            case (state)
                S_IDLE: begin
                    TxD      <= 1'b1;
                    baud_cnt <= '0;
                end
                S_START: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        bit_idx  <= '0;
                        TxD      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                TxD   <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                TxD      <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift   <= shift >> 1;
                            TxD     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        TxD      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    // Non-empty FIFO at the final boundary is handled by pop_c
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        TxD      <= 1'b1;
                        if (stop_idx == STOP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    TxD      <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
